// File: rtl/fifo_drain_bram.sv
// Drains DEPTH words from a standard-mode FIFO into BRAM addresses 0..DEPTH-1,
// then holds a sticky done flag until the next accepted start.
module fifo_drain_bram #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 10
) (
    input  logic              fclk,
    input  logic              reset,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counters are one bit wider than the address so DEPTH = 2^ADDR_W does not wrap.
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_V  = DEPTH_V - (ADDR_W + 1)'(1);

    state_t          state;
    logic [ADDR_W:0] rd_cnt;
    logic [ADDR_W:0] wr_cnt;
    logic            vld;

    // Handshake: a read is issued in any RUN cycle where the FIFO is not empty and
    // fewer than DEPTH reads have gone out; fifo_dout is valid one cycle later,
    // which is exactly when vld (and thus bram_we) is high for that word.
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (rd_cnt < DEPTH_V);
    assign bram_we    = vld;
    assign bram_din   = fifo_dout;
    assign bram_addr  = wr_cnt[ADDR_W-1:0];
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign count      = wr_cnt;
    assign dbg_state  = state;

    always_ff @(posedge fclk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
            vld    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    vld <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                    end
                end
                RUN: begin
                    vld <= fifo_rd_en;
                    if (fifo_rd_en) begin
                        rd_cnt <= rd_cnt + (ADDR_W + 1)'(1);
                    end
                    if (vld) begin
                        wr_cnt <= wr_cnt + (ADDR_W + 1)'(1);
                        if (wr_cnt == LAST_V) begin
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    vld   <= 1'b0;
                end
            endcase
        end
    end

endmodule
